// File: rtl/echo_requester.sv
// Echo request initiator: issues COUNT `say` requests, checks returned `heard` indications.
// Optional watchdog (ECHO_REQ_TIMEOUT_EN) ends a stalled run with timeout=1.
module echo_requester #(
  parameter int unsigned COUNT           = 16,
  parameter logic [31:0] START           = 32'h1,
  parameter logic [31:0] STEP            = 32'h1,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start__ENA,
  output logic        start__RDY,
  output logic        say__ENA,
  output logic [31:0] say_say_v,
  input  logic        say__RDY,
  input  logic        heard__ENA,
  input  logic [31:0] heard_v,
  output logic        heard__RDY,
  output logic        busy,
  output logic        done,
  output logic [15:0] rx_count,
  output logic [15:0] err_count,
  output logic        timeout
);

  // Handshake: a transfer fires in any cycle where ENA and RDY are both high at posedge CLK.
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [31:0] COUNT_W = 32'(COUNT);
  localparam logic [7:0]  MAX_OUT = 8'(MAX_OUTSTANDING);

  state_t      state, state_nxt;
  logic [31:0] tx_value, exp_value, tx_sent, tx_sent_nxt;
  logic [7:0]  outstanding, outstanding_nxt;
  logic        start_fire, say_fire, heard_fire, wd_expire;

  assign start__RDY = (state == IDLE) || (state == DONE);
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == DONE);
  assign heard__RDY = busy && (outstanding != 8'd0);
  assign say__ENA   = (state == RUN) && say__RDY && (outstanding < MAX_OUT) && (tx_sent < COUNT_W);
  assign say_say_v  = (state == RUN) ? tx_value : 32'd0;

  assign start_fire  = start__ENA && start__RDY;
  assign say_fire    = say__ENA;
  assign heard_fire  = heard__ENA && heard__RDY;
  assign tx_sent_nxt = tx_sent + {31'd0, say_fire};

  always_comb begin
    outstanding_nxt = outstanding;
    case ({say_fire, heard_fire})
      2'b10:   outstanding_nxt = outstanding + 8'd1;
      2'b01:   outstanding_nxt = outstanding - 8'd1;
      default: outstanding_nxt = outstanding;
    endcase
  end

`ifdef ECHO_REQ_TIMEOUT_EN
  logic [9:0] wd_cnt;
  logic       wd_active;
  // Expire on the cycle the counter would reach 1023.
  assign wd_active = busy && (outstanding != 8'd0) && !heard_fire;
  assign wd_expire = wd_active && (wd_cnt == 10'd1022);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wd_cnt  <= 10'd0;
      timeout <= 1'b0;
    end else if (start_fire) begin
      wd_cnt  <= 10'd0;
      timeout <= 1'b0;
    end else begin
      wd_cnt <= wd_active ? wd_cnt + 10'd1 : 10'd0;
      if (wd_expire) timeout <= 1'b1;
    end
  end
`else
  assign wd_expire = 1'b0;
  assign timeout   = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start_fire) state_nxt = (COUNT_W == 32'd0) ? DONE : RUN;
      RUN: begin
        if (wd_expire)                                state_nxt = DONE;
        else if (say_fire && tx_sent_nxt == COUNT_W)  state_nxt = DRAIN;
      end
      DRAIN: begin
        if (wd_expire || outstanding_nxt == 8'd0) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      tx_value    <= 32'd0;
      exp_value   <= 32'd0;
      tx_sent     <= 32'd0;
      outstanding <= 8'd0;
      rx_count    <= 16'd0;
      err_count   <= 16'd0;
    end else begin
      state <= state_nxt;
      if (start_fire) begin
        tx_value    <= START;
        exp_value   <= START;
        tx_sent     <= 32'd0;
        outstanding <= 8'd0;
        rx_count    <= 16'd0;
        err_count   <= 16'd0;
      end else begin
        outstanding <= outstanding_nxt;
        if (say_fire) begin
          tx_value <= tx_value + STEP;
          tx_sent  <= tx_sent_nxt;
        end
        if (heard_fire) begin
          rx_count  <= rx_count + 16'd1;
          exp_value <= exp_value + STEP;
          if (heard_v != exp_value && err_count != 16'hFFFF)
            err_count <= err_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_echo_requester.sv
// Directed bench for echo_requester: loopback, corruption, backpressure, mid-run reset, COUNT=0,
// and the watchdog when ECHO_REQ_TIMEOUT_EN is defined.
module tb_echo_requester;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        start__ENA = 1'b0, start0 = 1'b0;
  logic        say__RDY = 1'b1;
  logic        heard__ENA = 1'b0;
  logic [31:0] heard_v = 32'd0;
  logic        start__RDY, say__ENA, heard__RDY, busy, done, timeout;
  logic [31:0] say_say_v;
  logic [15:0] rx_count, err_count;

  logic        start_rdy0, say_ena0, heard_rdy0, busy0, done0, timeout0;
  logic [31:0] say_v0;
  logic [15:0] rx0, err0;

  echo_requester #(.COUNT(4), .START(32'h1), .STEP(32'h1), .MAX_OUTSTANDING(2)) dut (
    .CLK(CLK), .nRST(nRST), .start__ENA(start__ENA), .start__RDY(start__RDY),
    .say__ENA(say__ENA), .say_say_v(say_say_v), .say__RDY(say__RDY),
    .heard__ENA(heard__ENA), .heard_v(heard_v), .heard__RDY(heard__RDY),
    .busy(busy), .done(done), .rx_count(rx_count), .err_count(err_count), .timeout(timeout)
  );

  echo_requester #(.COUNT(0), .START(32'h1), .STEP(32'h1), .MAX_OUTSTANDING(2)) dut0 (
    .CLK(CLK), .nRST(nRST), .start__ENA(start0), .start__RDY(start_rdy0),
    .say__ENA(say_ena0), .say_say_v(say_v0), .say__RDY(say__RDY),
    .heard__ENA(1'b0), .heard_v(32'd0), .heard__RDY(heard_rdy0),
    .busy(busy0), .done(done0), .rx_count(rx0), .err_count(err0), .timeout(timeout0)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int          total = 0, bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] echo_q[$];
  int          say_fires = 0, heard_returned = 0, say0_seen = 0;
  int          cyc = 0, last_say_cyc = 0;
  bit          echo_on = 1'b0;
  int          corrupt_at = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start_rdy"}, start__RDY, 1);
    check({tag, "_say_ena"},   say__ENA, 0);
    check({tag, "_say_v"},     say_say_v, 0);
    check({tag, "_heard_rdy"}, heard__RDY, 0);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_done"},      done, 0);
    check({tag, "_rx"},        rx_count, 0);
    check({tag, "_err"},       err_count, 0);
    check({tag, "_timeout"},   timeout, 0);
  endtask

  // One clock cycle: drive the echo model, observe fires, advance to posedge+1.
  task automatic tick();
    heard__ENA = 1'b0;
    heard_v    = 32'd0;
    if (echo_on && echo_q.size() > 0 && heard__RDY) begin
      heard__ENA = 1'b1;
      heard_v    = (heard_returned + 1 == corrupt_at) ? 32'd7 : echo_q[0];
    end
    #1;
    if (say__ENA) begin
      say_fires++;
      last_say_cyc = cyc;
      if (exp_q.size() != 0) check("say_val", say_say_v, exp_q.pop_front());
      echo_q.push_back(say_say_v);
    end
    if (heard__ENA && heard__RDY) begin
      void'(echo_q.pop_front());
      heard_returned++;
    end
    if (say_ena0) say0_seen++;
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic start_run();
    heard_returned = 0;
    say_fires = 0;
    start__ENA = 1'b1;
    tick();
    start__ENA = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) tick();
    check({tag, "_done"}, done, 1);
  endtask

  task automatic load_exp(input int first, input int last);
    for (int v = first; v <= last; v++) exp_q.push_back(32'(v));
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    check_reset_vals("rst");
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    // Plain loopback: 1,2,3,4
    echo_on = 1'b1; corrupt_at = 0;
    load_exp(1, 4);
    start_run();
    check("lb_first_say", say__ENA, 1);
    wait_done("lb", 50);
    check("lb_fires", say_fires, 4);
    check("lb_rx", rx_count, 4);
    check("lb_err", err_count, 0);
    check("lb_expq", exp_q.size(), 0);
    check("lb_busy", busy, 0);
    check("lb_start_rdy", start__RDY, 1);
    check("lb_timeout", timeout, 0);
    repeat (3) tick();
    check("lb_hold_rx", rx_count, 4);
    check("lb_hold_done", done, 1);

    // Third returned value corrupted 3 -> 7
    corrupt_at = 3;
    load_exp(1, 4);
    start_run();
    wait_done("cor", 50);
    check("cor_rx", rx_count, 4);
    check("cor_err", err_count, 1);
    corrupt_at = 0;

    // Echo withholds indications: only MAX_OUTSTANDING says go out
    echo_on = 1'b0;
    load_exp(1, 2);
    start_run();
    repeat (10) tick();
    check("hold_fires", say_fires, 2);
    check("hold_say_ena", say__ENA, 0);
    check("hold_heard_rdy", heard__RDY, 1);
    check("hold_busy", busy, 1);
    check("hold_rx", rx_count, 0);
    echo_on = 1'b1;
    load_exp(3, 4);
    wait_done("hold", 50);
    check("hold_fires_all", say_fires, 4);
    check("hold_rx_all", rx_count, 4);
    check("hold_err_all", err_count, 0);

    // Asynchronous reset in the middle of a run
    echo_on = 1'b0;
    load_exp(1, 2);
    start_run();
    repeat (3) tick();
    check("mid_fires", say_fires, 2);
    check("mid_busy", busy, 1);
    nRST = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    echo_q.delete();
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    echo_on = 1'b1;
    load_exp(1, 4);
    start_run();
    check("re_first_v", say_say_v, 1);
    wait_done("re", 50);
    check("re_fires", say_fires, 4);
    check("re_rx", rx_count, 4);
    check("re_err", err_count, 0);

    // COUNT=0 instance goes straight to DONE
    check("z_idle_done", done0, 0);
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("z_done", done0, 1);
    check("z_busy", busy0, 0);
    check("z_rx", rx0, 0);
    repeat (3) tick();
    check("z_no_say", say0_seen, 0);

`ifdef ECHO_REQ_TIMEOUT_EN
    // Indications never return: watchdog closes the run
    echo_on = 1'b0;
    echo_q.delete();
    load_exp(1, 2);
    start_run();
    for (int i = 0; i < 1200 && !done; i++) tick();
    check("wd_done", done, 1);
    check("wd_timeout", timeout, 1);
    check("wd_delay", cyc - last_say_cyc, 1023);
    check("wd_fires", say_fires, 2);
    check("wd_rx", rx_count, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
